// File: rtl/niu32_mmio.sv
// Memory-mapped I/O block for the Niu32 core: HEX/LEDR/LEDG registers, debounced KEY/SWITCH status.
// Latency: request sampled in IDLE completes with a one-cycle registered ack on the next cycle.
// Backpressure: one access at a time; req is held until ack, and no new request is taken during ACK.
module niu32_mmio #(
    parameter int          WORD_SIZE       = 32,
    parameter logic [31:0] ADDR_HEX        = 32'hFFFF0000,
    parameter logic [31:0] ADDR_LEDR       = 32'hFFFF0020,
    parameter logic [31:0] ADDR_LEDG       = 32'hFFFF0040,
    parameter logic [31:0] ADDR_KEY        = 32'hFFFF0100,
    parameter logic [31:0] ADDR_SWITCH     = 32'hFFFF0120,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic                 hit,
    output logic                 ack,
    output logic [WORD_SIZE-1:0] rdata,
    input  logic [3:0]           KEY,
    input  logic [9:0]           SWITCH,
    output logic [15:0]          hex_value,
    output logic [9:0]           LEDR,
    output logic [7:0]           LEDG
);

    localparam int              NIN     = 14;   // 4 keys + 10 switches debounced together
    localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t             state, state_nxt;
    logic [3:0]         key_meta, key_sync;
    logic [9:0]         sw_meta, sw_sync;
    logic [NIN-1:0]     synced, stable, accept;
    logic [CW-1:0]      cnt [NIN];
    logic [3:0]         key_stable, key_edge, key_rise;
    logic [9:0]         sw_stable;
    logic               sel_hex, sel_ledr, sel_ledg, sel_key, sel_sw;
    logic               do_wr, do_rd;
    logic [WORD_SIZE-1:0] rd_mux;
    logic               unused_wdata;

    assign unused_wdata = ^wdata[WORD_SIZE-1:16];

    // Two-flop synchronizers; keys idle high (released) so their flops reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta <= '1;
            key_sync <= '1;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= KEY;
            key_sync <= key_meta;
            sw_meta  <= SWITCH;
            sw_sync  <= sw_meta;
        end
    end

    // Keys are inverted here so every debounced bit reads 1 = active.
    assign synced     = {sw_sync, ~key_sync};
    assign key_stable = stable[3:0];
    assign sw_stable  = stable[NIN-1:4];

    // A bit is accepted once it has disagreed with the stable value for DEBOUNCE_CYCLES edges.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NIN; i++)
            accept[i] = (synced[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end

    assign key_rise = accept[3:0] & synced[3:0] & ~stable[3:0];

    // Per-bit debounce counters and accepted (stable) values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (synced[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= synced[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Exact address decode, no aliasing.
    assign sel_hex  = (addr == ADDR_HEX);
    assign sel_ledr = (addr == ADDR_LEDR);
    assign sel_ledg = (addr == ADDR_LEDG);
    assign sel_key  = (addr == ADDR_KEY);
    assign sel_sw   = (addr == ADDR_SWITCH);
    assign hit      = sel_hex | sel_ledr | sel_ledg | sel_key | sel_sw;

    assign do_wr = (state == S_IDLE) && req && we;
    assign do_rd = (state == S_IDLE) && req && !we;
    assign ack   = (state == S_ACK);

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // IDLE takes a request on the edge it is seen; ACK always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read data selection; unmapped addresses read as zero.
    always_comb begin
        rd_mux = '0;
        if (sel_hex)       rd_mux = {16'b0, hex_value};
        else if (sel_ledr) rd_mux = {22'b0, LEDR};
        else if (sel_ledg) rd_mux = {24'b0, LEDG};
        else if (sel_key)  rd_mux = {24'b0, key_edge, key_stable};
        else if (sel_sw)   rd_mux = {22'b0, sw_stable};
    end

    // Output registers, read data capture, and sticky key-press flags.
    // A press landing on the same edge as a KEY read survives the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_value <= '0;
            LEDR      <= '0;
            LEDG      <= '0;
            rdata     <= '0;
            key_edge  <= '0;
        end else begin
            if (do_wr && sel_hex)  hex_value <= wdata[15:0];
            if (do_wr && sel_ledr) LEDR      <= wdata[9:0];
            if (do_wr && sel_ledg) LEDG      <= wdata[7:0];
            if (do_rd)             rdata     <= rd_mux;
            key_edge <= ((do_rd && sel_key) ? 4'b0 : key_edge) | key_rise;
        end
    end

endmodule

// File: tb/tb_niu32_mmio.sv
// Directed self-checking bench for niu32_mmio.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Every access drops req in its ACK cycle, as the core does.
module tb_niu32_mmio;

    localparam int          D       = 16;
    localparam logic [31:0] A_HEX   = 32'hFFFF0000;
    localparam logic [31:0] A_LEDR  = 32'hFFFF0020;
    localparam logic [31:0] A_LEDG  = 32'hFFFF0040;
    localparam logic [31:0] A_KEY   = 32'hFFFF0100;
    localparam logic [31:0] A_SW    = 32'hFFFF0120;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic        hit, ack;
    logic [31:0] rdata;
    logic [3:0]  KEY;
    logic [9:0]  SWITCH;
    logic [15:0] hex_value;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        h;

    always #5 clk = ~clk;

    niu32_mmio #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .hit(hit), .ack(ack), .rdata(rdata), .KEY(KEY), .SWITCH(SWITCH),
        .hex_value(hex_value), .LEDR(LEDR), .LEDG(LEDG)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge with the FSM back in IDLE.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd_o, output logic hit_o);
        req = 1'b1; we = w; addr = a; wdata = d;
        #1 hit_o = hit;
        @(negedge clk);
        check("ack_pulse", {31'b0, ack}, 32'd1);
        rd_o = rdata;
        req = 1'b0;
        @(negedge clk);
        check("ack_single", {31'b0, ack}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        KEY = 4'hF; SWITCH = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ack",  {31'b0, ack}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_hex",  {16'b0, hex_value}, 32'd0);
        check("rst_ledr", {22'b0, LEDR}, 32'd0);
        check("rst_ledg", {24'b0, LEDG}, 32'd0);

        // LEDR write and readback
        access(1'b1, A_LEDR, 32'h0000_03A5, rd, h);
        check("hit_ledr", {31'b0, h}, 32'd1);
        check("ledr_wr", {22'b0, LEDR}, 32'h3A5);
        access(1'b0, A_LEDR, 32'h0, rd, h);
        check("ledr_rd", rd, 32'h0000_03A5);

        // HEX write keeps only low 16 bits
        access(1'b1, A_HEX, 32'hDEAD_BEEF, rd, h);
        check("hex_wr", {16'b0, hex_value}, 32'h0000_BEEF);
        access(1'b0, A_HEX, 32'h0, rd, h);
        check("hex_rd", rd, 32'h0000_BEEF);

        // Write to read-only KEY: nothing changes, rdata untouched
        access(1'b1, A_KEY, 32'hFFFF_FFFF, rd, h);
        check("rokey_hex",  {16'b0, hex_value}, 32'h0000_BEEF);
        check("rokey_ledr", {22'b0, LEDR}, 32'h3A5);
        check("rokey_ledg", {24'b0, LEDG}, 32'h0);
        check("wr_rdata_hold", rd, 32'h0000_BEEF);

        // Unmapped read
        access(1'b0, 32'hFFFF0004, 32'h0, rd, h);
        check("unmapped_hit", {31'b0, h}, 32'd0);
        check("unmapped_rd", rd, 32'h0);

        // KEY[2] press: stable exactly D+2 edges after the change
        KEY[2] = 1'b0;
        repeat (D + 1) @(negedge clk);
        check("key2_early", {31'b0, dut.key_stable[2]}, 32'd0);
        @(negedge clk);
        check("key2_ontime", {31'b0, dut.key_stable[2]}, 32'd1);
        access(1'b0, A_KEY, 32'h0, rd, h);
        check("key_rd1", rd, 32'h0000_0044);
        access(1'b0, A_KEY, 32'h0, rd, h);
        check("key_rd2", rd, 32'h0000_0004);

        // KEY[0] glitch of D-2 cycles is rejected
        KEY[0] = 1'b0;
        repeat (D - 2) @(negedge clk);
        KEY[0] = 1'b1;
        repeat (D + 5) @(negedge clk);
        check("glitch_stable", {31'b0, dut.key_stable[0]}, 32'd0);
        access(1'b0, A_KEY, 32'h0, rd, h);
        check("glitch_rd", rd, 32'h0000_0004);

        // Switches
        SWITCH = 10'h2C1;
        repeat (D + 3) @(negedge clk);
        access(1'b0, A_SW, 32'h0, rd, h);
        check("sw_rd", rd, 32'h0000_02C1);

        // KEY[1] press accepted on the very edge a KEY read is sampled
        KEY[1] = 1'b0;
        repeat (D + 1) @(negedge clk);
        access(1'b0, A_KEY, 32'h0, rd, h);
        check("race_rd", rd, 32'h0000_0004);
        check("race_edge_kept", {28'b0, dut.key_edge}, 32'h2);
        access(1'b0, A_KEY, 32'h0, rd, h);
        check("race_rd_after", rd, 32'h0000_0026);

        // Reset in the ACK cycle of a LEDG write
        req = 1'b1; we = 1'b1; addr = A_LEDG; wdata = 32'h0000_00FF;
        @(negedge clk);
        check("ledg_ack", {31'b0, ack}, 32'd1);
        check("ledg_wr", {24'b0, LEDG}, 32'hFF);
        req = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rstmid_ack",  {31'b0, ack}, 32'd0);
        check("rstmid_ledg", {24'b0, LEDG}, 32'h0);
        check("rstmid_rdata", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        access(1'b1, A_HEX, 32'h0000_1234, rd, h);
        access(1'b0, A_HEX, 32'h0, rd, h);
        check("post_rst_hex", rd, 32'h0000_1234);
        access(1'b0, A_LEDG, 32'h0, rd, h);
        check("post_rst_ledg", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
